// File: rtl/aes256_round_key_expander.sv
// Iterative AES-256 key schedule: expands a 256-bit cipher key into round keys
// rk0..rk14 and streams them, one per cycle, into the round-key memory write port.
module aes256_round_key_expander #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic              inStart,
  input  logic [255:0]      inKey,
  output logic              outBusy,
  output logic              outDone,
  output logic              outWr,
  output logic [ADDR_W-1:0] outAddr,
  output logic [DATA_W-1:0] outData
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'd14;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon indexed by i/2; entry 0 is never selected for an even i >= 2.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [127:0]         p2_q, p2_d;
  logic [127:0]         p1_q, p1_d;
  logic                 wr_q, wr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [127:0]         data_q, data_d;

  logic [31:0]          t_word;
  logic [31:0]          tmp_word;
  logic [31:0]          n0, n1, n2, n3;
  logic [127:0]         rk_next;
  logic [127:0]         rk_cur;

  // Next round key from the two previous ones: S-box followed by a 4-deep XOR chain.
  always_comb begin
    t_word = p1_q[31:0];
    if (!idx_q[0]) begin
      tmp_word = sub_word({t_word[23:0], t_word[31:24]}) ^ {RCON[idx_q[3:1]], 24'h0};
    end else begin
      tmp_word = sub_word(t_word);
    end
    n0      = p2_q[127:96] ^ tmp_word;
    n1      = p2_q[95:64]  ^ n0;
    n2      = p2_q[63:32]  ^ n1;
    n3      = p2_q[31:0]   ^ n2;
    rk_next = {n0, n1, n2, n3};

    // rk0/rk1 are the key halves themselves, parked in P2/P1 at capture.
    unique case (idx_q)
      4'd0:    rk_cur = p2_q;
      4'd1:    rk_cur = p1_q;
      default: rk_cur = rk_next;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    p2_d    = p2_q;
    p1_d    = p1_q;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (inStart) begin
          p2_d    = inKey[255:128];
          p1_d    = inKey[127:0];
          idx_d   = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        wr_d   = 1'b1;
        busy_d = 1'b1;
        addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
        data_d = rk_cur;
        if (idx_q >= 4'd2) begin
          p2_d = p1_q;
          p1_d = rk_next;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      p2_q    <= '0;
      p1_q    <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      p2_q    <= p2_d;
      p1_q    <= p1_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign outBusy = busy_q;
  assign outDone = done_q;
  assign outWr   = wr_q;
  assign outAddr = addr_q;
  assign outData = {{(DATA_W-128){1'b0}}, data_q};

endmodule

// File: tb/tb_aes256_round_key_expander.sv
// Scoreboard bench for the AES-256 round-key expander, checked against a
// word-wise FIPS-197 key expansion using an S-box derived from GF(2^8) inversion.
module tb_aes256_round_key_expander;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 256;
  localparam int unsigned BASE_ADDR = 0;

  logic              inClk = 1'b0;
  logic              inRstN;
  logic              inStart;
  logic [255:0]      inKey;
  logic              outBusy;
  logic              outDone;
  logic              outWr;
  logic [ADDR_W-1:0] outAddr;
  logic [DATA_W-1:0] outData;

  aes256_round_key_expander #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .inClk   (inClk),
    .inRstN  (inRstN),
    .inStart (inStart),
    .inKey   (inKey),
    .outBusy (outBusy),
    .outDone (outDone),
    .outWr   (outWr),
    .outAddr (outAddr),
    .outData (outData)
  );

  always #5 inClk = ~inClk;

  int unsigned cyc = 0;
  always @(posedge inClk) cyc <= cyc + 1;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    int unsigned       cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_q[$];

  // ---------------- reference model ----------------
  logic [7:0]   sbox_m [256];
  logic [31:0]  w_m    [60];
  logic [127:0] rk_m   [15];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'(x);
      logic [7:0] inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        repeat (254) inv = gmul(inv, b);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_m(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  task automatic build_model(input logic [255:0] key);
    logic [7:0]  rc = 8'h01;
    logic [31:0] temp;
    for (int i = 0; i < 8; i++) w_m[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w_m[i-1];
      if (i % 8 == 0) begin
        temp = sub_m({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = xtime(rc);
      end else if (i % 8 == 4) begin
        temp = sub_m(temp);
      end
      w_m[i] = w_m[i-8] ^ temp;
    end
    for (int r = 0; r < 15; r++) rk_m[r] = {w_m[4*r], w_m[4*r+1], w_m[4*r+2], w_m[4*r+3]};
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic issue(input logic [255:0] key);
    int unsigned t_edge;
    exp_t e;
    build_model(key);
    t_edge = cyc + 1;
    for (int r = 0; r < 15; r++) begin
      e.cyc  = t_edge + 1 + r;
      e.addr = ADDR_W'(BASE_ADDR + r);
      e.data = {{(DATA_W-128){1'b0}}, rk_m[r]};
      exp_q.push_back(e);
    end
    done_q.push_back(t_edge + 16);
    inKey   = key;
    inStart = 1'b1;
    @(negedge inClk);
    inStart = 1'b0;
    inKey   = {8{$urandom()}};
  endtask

  task automatic wait_done();
    int n = 0;
    while (!outDone && n < 40) begin
      @(negedge inClk);
      n++;
    end
    n_vec++;
    if (!outDone) begin
      n_fail++;
      $display("FAIL done_timeout: outDone=%b after %0d cycles, expected 1", outDone, n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 40) begin
      @(negedge inClk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d writes and %0d done pulses outstanding, expected 0",
               exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
  endtask

  task automatic check_model(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t        mon_e;
  int unsigned mon_d;
  always @(negedge inClk) begin
    if (outWr) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: cyc=%0d addr=%0d, expected no write", cyc, outAddr);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || outAddr !== mon_e.addr || outData !== mon_e.data || outBusy !== 1'b1) begin
          n_fail++;
          $display("FAIL write: got cyc=%0d addr=%0d busy=%b data=%h, expected cyc=%0d addr=%0d busy=1 data=%h",
                   cyc, outAddr, outBusy, outData, mon_e.cyc, mon_e.addr, mon_e.data);
        end
      end
    end else if (outBusy) begin
      n_vec++;
      n_fail++;
      $display("FAIL busy_no_write: outBusy=%b outWr=%b, expected busy only with a write", outBusy, outWr);
    end
    if (outDone) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: cyc=%0d, expected no outDone", cyc);
      end else begin
        mon_d = done_q.pop_front();
        if (cyc != mon_d || outWr !== 1'b0) begin
          n_fail++;
          $display("FAIL done: got cyc=%0d wr=%b, expected cyc=%0d wr=0", cyc, outWr, mon_d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  localparam logic [255:0] SEQ_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [255:0] rkey;
    inRstN  = 1'b0;
    inStart = 1'b0;
    inKey   = '0;
    init_sbox();

    // Reset state
    #1;
    n_vec++;
    if ({outBusy, outDone, outWr} !== 3'b000 || outAddr !== '0 || outData !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b wr=%b addr=%h data=%h, expected all 0",
               outBusy, outDone, outWr, outAddr, outData);
    end
    @(negedge inClk);
    @(negedge inClk);
    inRstN = 1'b1;

    // Idle with no start: never writes
    for (int i = 0; i < 20; i++) begin
      @(negedge inClk);
      n_vec++;
      if (outWr !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_wr: outWr=%b at idle cycle %0d, expected 0", outWr, i);
      end
    end

    // Known-answer run; second start during GEN must be ignored
    build_model(SEQ_KEY);
    check_model("model_rk0",  rk_m[0],  128'h000102030405060708090a0b0c0d0e0f);
    check_model("model_rk1",  rk_m[1],  128'h101112131415161718191a1b1c1d1e1f);
    check_model("model_rk2",  rk_m[2],  128'ha573c29fa176c498a97fce93a572c09c);
    check_model("model_rk14", rk_m[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    issue(SEQ_KEY);
    repeat (4) @(negedge inClk);
    inKey   = {8{32'hdeadbeef}};
    inStart = 1'b1;
    @(negedge inClk);
    inStart = 1'b0;
    wait_idle();
    repeat (3) @(negedge inClk);

    // Reset while write 7 is on the bus
    rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
    issue(rkey);
    repeat (8) @(negedge inClk);
    #2 inRstN = 1'b0;
    #1;
    n_vec++;
    if ({outWr, outBusy, outDone} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: wr=%b busy=%b done=%b, expected 0 0 0", outWr, outBusy, outDone);
    end
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge inClk);
    inRstN = 1'b1;
    repeat (20) @(negedge inClk);
    issue(rkey);
    wait_idle();

    // All-zero key, restarted right after outDone
    build_model('0);
    check_model("model_zero_rk2", rk_m[2], 128'h62636363626363636263636362636363);
    @(negedge inClk);
    issue('0);
    wait_done();
    issue('0);
    wait_idle();

    // Random keys with random gaps, some back-to-back
    for (int k = 0; k < 8; k++) begin
      rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
      repeat ($urandom_range(0, 4)) @(negedge inClk);
      issue(rkey);
      if ($urandom_range(0, 1) == 1) begin
        wait_done();
      end else begin
        wait_idle();
        @(negedge inClk);
      end
    end
    wait_idle();
    repeat (3) @(negedge inClk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
